// File: rtl/timer_scheduler.sv
// Multi-channel timer scheduler: one shared prescaler produces base_tick, and each
// channel counts base ticks down in one-shot or periodic mode under a config handshake.
module timer_scheduler #(
    parameter int CLK_DIV = 50000,
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PS_W   = $clog2(CLK_DIV)
) (
    input  logic              clk_in,
    input  logic              Reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_op,
    input  logic [CNT_W-1:0]  cfg_period,
    output logic              cfg_err,
    output logic              base_tick,
    output logic [NUM_CH-1:0] expire,
    output logic [NUM_CH-1:0] active
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
    localparam logic [1:0]      OP_RSVD = 2'b11;

    logic [PS_W-1:0] presc_reg;
    logic            base_tick_reg;
    logic            cfg_ready_reg;
    logic            cfg_err_reg;

    logic accept;
    logic bad_req;
    logic apply;

    always_ff @(posedge clk_in or posedge Reset) begin
        if (Reset) begin
            presc_reg     <= '0;
            base_tick_reg <= 1'b0;
        end else begin
            base_tick_reg <= (presc_reg == PS_LAST);
            presc_reg     <= (presc_reg == PS_LAST) ? '0 : presc_reg + PS_W'(1);
        end
    end

    // A start with zero period or the reserved op is consumed but leaves channels untouched.
    assign accept  = cfg_valid & cfg_ready_reg;
    assign bad_req = (cfg_op == OP_RSVD) | (~cfg_op[1] & (cfg_period == '0));
    assign apply   = accept & ~bad_req;

    always_ff @(posedge clk_in or posedge Reset) begin
        if (Reset) begin
            cfg_ready_reg <= 1'b1;
            cfg_err_reg   <= 1'b0;
        end else begin
            cfg_ready_reg <= ~accept;
            cfg_err_reg   <= accept & bad_req;
        end
    end

    assign cfg_ready = cfg_ready_reg;
    assign cfg_err   = cfg_err_reg;
    assign base_tick = base_tick_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] remaining_reg;
            logic [CNT_W-1:0] period_reg;
            logic             periodic_reg;
            logic             active_reg;
            logic             expire_reg;
            logic             hit;

            assign hit = apply & (cfg_ch == CH_W'(gi));

            // A request landing on a tick cycle wins; the tick is dropped for this channel.
            always_ff @(posedge clk_in or posedge Reset) begin
                if (Reset) begin
                    remaining_reg <= '0;
                    period_reg    <= '0;
                    periodic_reg  <= 1'b0;
                    active_reg    <= 1'b0;
                    expire_reg    <= 1'b0;
                end else begin
                    expire_reg <= 1'b0;
                    if (hit) begin
                        if (cfg_op[1]) begin
                            active_reg    <= 1'b0;
                            remaining_reg <= '0;
                        end else begin
                            remaining_reg <= cfg_period;
                            period_reg    <= cfg_period;
                            periodic_reg  <= cfg_op[0];
                            active_reg    <= 1'b1;
                        end
                    end else if (base_tick_reg && active_reg) begin
                        if (remaining_reg == CNT_W'(1)) begin
                            expire_reg <= 1'b1;
                            if (periodic_reg) begin
                                remaining_reg <= period_reg;
                            end else begin
                                active_reg    <= 1'b0;
                                remaining_reg <= '0;
                            end
                        end else begin
                            remaining_reg <= remaining_reg - CNT_W'(1);
                        end
                    end
                end
            end

            assign active[gi] = active_reg;
            assign expire[gi] = expire_reg;
        end
    endgenerate

endmodule
